regfile_wb_arbiter: RTL and testbench

//  Round-robin arbiter sharing the register file's single write port (rd/data/reg_write)

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the register file's single write port
//   between NUM_SRC writeback sources (ALU, load unit, CSR unit, ...).
//   One write is granted per clock via a valid/ready handshake. The granted
//   write is captured in a registered output stage that drives the register
//   file, which commits it on the following negedge. A saturating counter
//   records cycles in which two or more sources competed.
//
// Optional feature (macro WB_BYPASS_EN):
//   When defined, adds a forwarding path so decode can see the value that
//   the register file is about to commit:
//     rsN_byp_hit = reg_write_out && rd_out == rsN && rsN != 0
//     byp_data    = data_out
//   When undefined, these ports and that logic do not exist.
//
// Ports:
//   clock          in   system clock, all state updates on posedge
//   reset          in   synchronous, active-high
//   src_valid      in   [NUM_SRC]        source i has a pending write
//   src_ready      out  [NUM_SRC]        one-hot grant; transfer on valid&ready
//   src_rd         in   [NUM_SRC*ADDR_W] dest index, source i at [i*ADDR_W +: ADDR_W]
//   src_data       in   [NUM_SRC*DATA_W] write data, source i at [i*DATA_W +: DATA_W]
//   rd_out         out  [ADDR_W]         register file rd
//   data_out       out  [DATA_W]         register file write data
//   reg_write_out  out  1                register file write enable (1-cycle pulse)
//   rs1, rs2       in   [ADDR_W]         decode read indices      (WB_BYPASS_EN)
//   rs1_byp_hit    out  1                rs1 matches pending write (WB_BYPASS_EN)
//   rs2_byp_hit    out  1                rs2 matches pending write (WB_BYPASS_EN)
//   byp_data       out  [DATA_W]         pending write data        (WB_BYPASS_EN)
//   contention_cnt out  [CNT_W]          saturating count of cycles with >=2 valid
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0]         rd_out,
  output logic [DATA_W-1:0]         data_out,
  output logic                      reg_write_out,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  output logic                      rs1_byp_hit,
  output logic                      rs2_byp_hit,
  output logic [DATA_W-1:0]         byp_data,
`endif
  output logic [CNT_W-1:0]          contention_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand_idx;
  logic              win_found;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;
  int                valid_cnt;
  logic              multi_valid;

  // Winner search. The scan runs from the farthest offset back to rr_ptr
  // itself, so the last hit written is the one closest to rr_ptr.
  // NOTE: every always_comb output gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (src_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    valid_cnt = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      valid_cnt = valid_cnt + int'(src_valid[i]);
    end
    multi_valid = (valid_cnt >= 2);
  end

  assign win_rd   = src_rd[win_idx*ADDR_W +: ADDR_W];
  assign win_data = src_data[win_idx*DATA_W +: DATA_W];

  // Grants are gated by reset combinationally so no source sees a transfer
  // that the reset branch of the state register would then discard.
  assign src_ready = (win_found && !reset) ? (NUM_SRC'(1) << win_idx) : '0;

  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    we_d     = 1'b0;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (win_found) begin
      rd_d     = win_rd;
      data_d   = win_data;
      // x0 writes complete the handshake but never strobe the register file.
      we_d     = (win_rd != '0);
      rr_ptr_d = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
    end
    if (multi_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_out         = rd_q;
  assign data_out       = data_q;
  assign reg_write_out  = we_q;
  assign contention_cnt = cnt_q;

`ifdef WB_BYPASS_EN
  // Decode reads the register file before the negedge commit; forward the
  // pending write so the value is visible one cycle early.
  assign rs1_byp_hit = we_q && (rd_q == rs1) && (rs1 != '0);
  assign rs2_byp_hit = we_q && (rd_q == rs2) && (rs2 != '0);
  assign byp_data    = data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed testbench for regfile_wb_arbiter (NUM_SRC=3, ADDR_W=5, DATA_W=32,
// CNT_W=4 so saturation is reachable quickly). Inputs change 1 time unit
// after posedge; outputs are compared 1 time unit after that (combinational
// grant) or 1 time unit after posedge (registered outputs).
// The bypass section is compiled only when WB_BYPASS_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int NUM_SRC = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;

  logic                      clock;
  logic                      reset;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_rd;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [ADDR_W-1:0]         rd_out;
  logic [DATA_W-1:0]         data_out;
  logic                      reg_write_out;
  logic [CNT_W-1:0]          contention_cnt;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0]         rs1;
  logic [ADDR_W-1:0]         rs2;
  logic                      rs1_byp_hit;
  logic                      rs2_byp_hit;
  logic [DATA_W-1:0]         byp_data;
`endif

  int checks;
  int failures;

  regfile_wb_arbiter #(
    .NUM_SRC(NUM_SRC),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_rd        (src_rd),
    .src_data      (src_data),
    .rd_out        (rd_out),
    .data_out      (data_out),
    .reg_write_out (reg_write_out),
`ifdef WB_BYPASS_EN
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_byp_hit   (rs1_byp_hit),
    .rs2_byp_hit   (rs2_byp_hit),
    .byp_data      (byp_data),
`endif
    .contention_cnt(contention_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] data);
    src_rd[idx*ADDR_W +: ADDR_W]   = rd;
    src_data[idx*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    int               exp_src;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    src_valid = 3'b111;
    src_rd    = '0;
    src_data  = '0;
`ifdef WB_BYPASS_EN
    rs1 = '0;
    rs2 = '0;
`endif
    set_src(0, 5'd9, 32'h0000_0009);
    set_src(1, 5'd10, 32'h0000_000A);
    set_src(2, 5'd11, 32'h0000_000B);

    // 1: reset held two cycles with all sources valid
    #1;
    check("rst_ready_pre", src_ready, 3'b000);
    tick();
    check("rst_ready_c1", src_ready, 3'b000);
    check("rst_we_c1", reg_write_out, 1'b0);
    check("rst_cnt_c1", contention_cnt, 4'd0);
    check("rst_rd_c1", rd_out, 5'd0);
    check("rst_data_c1", data_out, 32'd0);
    tick();
    check("rst_ready_c2", src_ready, 3'b000);
    check("rst_we_c2", reg_write_out, 1'b0);
    check("rst_cnt_c2", contention_cnt, 4'd0);

    // 2: single write from source 1
    reset     = 1'b0;
    src_valid = 3'b010;
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("single_ready", src_ready, 3'b010);
    tick();
    src_valid = 3'b000;
    check("single_we", reg_write_out, 1'b1);
    check("single_rd", rd_out, 5'd5);
    check("single_data", data_out, 32'hDEAD_BEEF);
    tick();
    check("single_we_drop", reg_write_out, 1'b0);
    check("single_cnt", contention_cnt, 4'd0);

    // 4: x0 write from source 2 (rr_ptr is 2 here, becomes 0)
    src_valid = 3'b100;
    set_src(2, 5'd0, 32'hAAAA_0000);
    #1;
    check("x0_ready", src_ready, 3'b100);
    tick();
    src_valid = 3'b000;
    check("x0_we", reg_write_out, 1'b0);
    check("x0_rd", rd_out, 5'd0);
    check("x0_data", data_out, 32'hAAAA_0000);
    tick();
    check("x0_we_after", reg_write_out, 1'b0);

    // 3: round robin, all valid at rr_ptr=0, each drops after its grant
    set_src(0, 5'd1, 32'h1111_1111);
    set_src(1, 5'd2, 32'h2222_2222);
    set_src(2, 5'd3, 32'h3333_3333);
    src_valid = 3'b111;
    #1;
    check("rr_ready0", src_ready, 3'b001);
    tick();
    check("rr_we0", reg_write_out, 1'b1);
    check("rr_rd0", rd_out, 5'd1);
    check("rr_data0", data_out, 32'h1111_1111);
    src_valid = 3'b110;
    #1;
    check("rr_ready1", src_ready, 3'b010);
    tick();
    check("rr_we1", reg_write_out, 1'b1);
    check("rr_rd1", rd_out, 5'd2);
    src_valid = 3'b100;
    #1;
    check("rr_ready2", src_ready, 3'b100);
    tick();
    check("rr_we2", reg_write_out, 1'b1);
    check("rr_rd2", rd_out, 5'd3);
    check("rr_cnt", contention_cnt, 4'd2);
    // rr_ptr back at 0: with 0 and 2 valid, 0 must win
    src_valid = 3'b101;
    #1;
    check("rr_ptr_zero", src_ready, 3'b001);

    // 5: sources 0 and 1 held for 20 cycles; grants alternate, counter saturates
    src_valid = 3'b011;
    exp_cnt   = 4'd2;
    for (int c = 0; c < 20; c++) begin
      exp_src = c % 2;
      #1;
      check($sformatf("sat_ready_%0d", c), src_ready, 3'(1 << exp_src));
      tick();
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      check($sformatf("sat_we_%0d", c), reg_write_out, 1'b1);
      check($sformatf("sat_rd_%0d", c), rd_out, 5'(exp_src + 1));
      check($sformatf("sat_cnt_%0d", c), contention_cnt, exp_cnt);
    end
    check("sat_final", contention_cnt, 4'hF);
    src_valid = 3'b000;
    tick();
    check("idle_we", reg_write_out, 1'b0);
    check("idle_rd_hold", rd_out, 5'd2);
    check("idle_data_hold", data_out, 32'h2222_2222);
    check("idle_cnt_hold", contention_cnt, 4'hF);

    // Reset mid-operation: in-flight write dropped, pending request survives
    src_valid = 3'b010;
    #1;
    check("mid_ready", src_ready, 3'b010);
    tick();
    check("mid_we", reg_write_out, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", src_ready, 3'b000);
    tick();
    check("mid_rst_we", reg_write_out, 1'b0);
    check("mid_rst_cnt", contention_cnt, 4'd0);
    check("mid_rst_rd", rd_out, 5'd0);
    reset = 1'b0;
    #1;
    check("mid_pending_ready", src_ready, 3'b010);
    tick();
    src_valid = 3'b000;
    check("mid_pending_we", reg_write_out, 1'b1);
    check("mid_pending_rd", rd_out, 5'd2);
    check("mid_pending_data", data_out, 32'h2222_2222);
    tick();
    check("mid_pending_drop", reg_write_out, 1'b0);

`ifdef WB_BYPASS_EN
    // 6: bypass of a pending write to x7
    set_src(0, 5'd7, 32'h1234_5678);
    src_valid = 3'b001;
    #1;
    check("byp_ready", src_ready, 3'b001);
    tick();
    src_valid = 3'b000;
    rs1 = 5'd7;
    rs2 = 5'd0;
    #1;
    check("byp_hit1", rs1_byp_hit, 1'b1);
    check("byp_hit2_x0", rs2_byp_hit, 1'b0);
    check("byp_data", byp_data, 32'h1234_5678);
    rs2 = 5'd7;
    #1;
    check("byp_hit2", rs2_byp_hit, 1'b1);
    tick();
    check("byp_hit1_gone", rs1_byp_hit, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
